// File: rtl/imu_sample_framer.sv
// Captures IMU register-reader bursts into two ping-pong banks and drains each
// committed bank as header + timestamp + data words over a valid/ready stream.
module imu_sample_framer #(
  parameter int MAX_WORDS = 16,
  parameter int TS_W      = 32
) (
  input  logic        c,
  input  logic        rst_n,
  input  logic        rd_start,
  input  logic [7:0]  rd_reg_idx,
  input  logic [31:0] rd_d,
  input  logic        rd_dv,
  input  logic        rd_done,
  output logic [31:0] out_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [15:0] drop_cnt
);

  localparam int         AW   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [4:0] MAXW = 5'(MAX_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_CAP, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_HDR, R_TS, R_DATA} rstate_t;

  // Control state
  logic [TS_W-1:0] ts_q;
  logic [7:0]      seq_q;
  logic [1:0]      full_q;
  logic            last_commit_q;
  wstate_t         wstate_q;
  logic            wbank_q;
  logic [4:0]      wcnt_q;
  logic            trunc_q;
  logic [15:0]     drop_q;
  rstate_t         rstate_q;
  logic            rbank_q;
  logic [4:0]      rk_q;
  logic [31:0]     odata_q;
  logic            ovalid_q;
  logic            olast_q;

  // Bank storage and per-bank frame metadata
  logic [31:0]     mem_q     [2][MAX_WORDS];
  logic [TS_W-1:0] b_ts_q    [2];
  logic [7:0]      b_idx_q   [2];
  logic [4:0]      b_wcnt_q  [2];
  logic            b_trunc_q [2];
  logic [7:0]      b_seq_q   [2];

  logic        hs, rd_free, in_cap;
  logic [1:0]  full_set, full_clr, free;
  logic        any_free, pick, sbank, meta_load;
  logic        cap_wr, cap_ovf, commit;
  logic [4:0]  wcnt_d;
  logic        trunc_d;
  logic        rsel;
  logic [31:0] hdr_word;

  always_comb begin
    hs       = ovalid_q & out_ready;
    rd_free  = hs & olast_q;
    full_clr = rd_free ? (rbank_q ? 2'b10 : 2'b01) : 2'b00;
    // A bank released by this cycle's final handshake is already offered to rd_start.
    free     = ~full_q | full_clr;
    any_free = |free;
    pick     = ~free[0];

    in_cap   = (wstate_q == W_CAP);
    cap_wr   = in_cap & ~rd_start & rd_dv & (wcnt_q < MAXW);
    cap_ovf  = in_cap & ~rd_start & rd_dv & (wcnt_q == MAXW);
    commit   = in_cap & ~rd_start & rd_done;
    wcnt_d   = wcnt_q + (cap_wr ? 5'd1 : 5'd0);
    trunc_d  = trunc_q | cap_ovf;
    full_set = commit ? (wbank_q ? 2'b10 : 2'b01) : 2'b00;

    sbank     = in_cap ? wbank_q : pick;
    meta_load = rd_start & (in_cap | any_free);

    rsel     = (&full_q) ? ~last_commit_q : ~full_q[0];
    hdr_word = {8'hA5, b_idx_q[rsel], b_wcnt_q[rsel], b_trunc_q[rsel], 2'b00, b_seq_q[rsel]};
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      ts_q          <= '0;
      seq_q         <= '0;
      full_q        <= '0;
      last_commit_q <= 1'b0;
      wstate_q      <= W_IDLE;
      wbank_q       <= 1'b0;
      wcnt_q        <= '0;
      trunc_q       <= 1'b0;
      drop_q        <= '0;
    end else begin
      ts_q   <= ts_q + TS_W'(1);
      full_q <= (full_q & ~full_clr) | full_set;
      case (wstate_q)
        W_CAP: begin
          if (rd_start) begin
            wcnt_q  <= '0;
            trunc_q <= 1'b0;
          end else begin
            wcnt_q  <= wcnt_d;
            trunc_q <= trunc_d;
            if (rd_done) begin
              wstate_q      <= W_IDLE;
              seq_q         <= seq_q + 8'd1;
              last_commit_q <= wbank_q;
            end
          end
        end
        default: begin
          if (rd_start) begin
            if (any_free) begin
              wbank_q  <= pick;
              wcnt_q   <= '0;
              trunc_q  <= 1'b0;
              wstate_q <= W_CAP;
            end else begin
              if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
              wstate_q <= W_DROP;
            end
          end else if (rd_done) begin
            wstate_q <= W_IDLE;
          end
        end
      endcase
    end
  end

  // NOTE: bank contents and metadata have no reset; full_q gates every read of them.
  always_ff @(posedge c) begin
    if (cap_wr) mem_q[wbank_q][wcnt_q[AW-1:0]] <= rd_d;
    if (meta_load) begin
      b_ts_q[sbank]  <= ts_q;
      b_idx_q[sbank] <= rd_reg_idx;
    end
    if (commit) begin
      b_wcnt_q[wbank_q]  <= wcnt_d;
      b_trunc_q[wbank_q] <= trunc_d;
      b_seq_q[wbank_q]   <= seq_q;
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      rbank_q  <= 1'b0;
      rk_q     <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (|full_q) begin
            rbank_q  <= rsel;
            odata_q  <= hdr_word;
            ovalid_q <= 1'b1;
            olast_q  <= 1'b0;
            rstate_q <= R_HDR;
          end
        end
        R_HDR: begin
          if (hs) begin
            odata_q  <= 32'(b_ts_q[rbank_q]);
            olast_q  <= (b_wcnt_q[rbank_q] == 5'd0);
            rk_q     <= '0;
            rstate_q <= R_TS;
          end
        end
        default: begin
          if (hs) begin
            if (olast_q) begin
              ovalid_q <= 1'b0;
              olast_q  <= 1'b0;
              rstate_q <= R_IDLE;
            end else begin
              odata_q  <= mem_q[rbank_q][rk_q[AW-1:0]];
              olast_q  <= (rk_q == b_wcnt_q[rbank_q] - 5'd1);
              rk_q     <= rk_q + 5'd1;
              rstate_q <= R_DATA;
            end
          end
        end
      endcase
    end
  end

  assign out_d     = odata_q;
  assign out_valid = ovalid_q;
  assign out_last  = olast_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_imu_sample_framer.sv
// Directed bench for imu_sample_framer: stimulus pushes expected stream words into
// a scoreboard queue; a negedge monitor pops and compares on every handshake.
module tb_imu_sample_framer;

  logic        c = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_start = 1'b0;
  logic [7:0]  rd_reg_idx = '0;
  logic [31:0] rd_d = '0;
  logic        rd_dv = 1'b0;
  logic        rd_done = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_d;
  logic        out_valid;
  logic        out_last;
  logic [15:0] drop_cnt;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          ready_mode = 0;
  logic [7:0]  exp_seq = '0;

  typedef struct {
    logic [31:0] d;
    logic        last;
  } exp_t;
  exp_t sb[$];

  imu_sample_framer #(.MAX_WORDS(16), .TS_W(32)) dut (
    .c(c), .rst_n(rst_n), .rd_start(rd_start), .rd_reg_idx(rd_reg_idx),
    .rd_d(rd_d), .rd_dv(rd_dv), .rd_done(rd_done), .out_d(out_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .drop_cnt(drop_cnt)
  );

  always #5 c = ~c;

  // Independent model of the free-running timestamp.
  always @(posedge c or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [7:0] idx, input logic [4:0] n,
                                      input logic t, input logic [7:0] s);
    return {8'hA5, idx, n, t, 2'b00, s};
  endfunction

  task automatic push_w(input logic [31:0] d, input logic last);
    exp_t e;
    e.d = d;
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic drive(input bit s, input logic [7:0] idx, input bit dv,
                       input logic [31:0] d, input bit dn);
    step();
    rd_start   = s;
    rd_reg_idx = idx;
    rd_dv      = dv;
    rd_d       = d;
    rd_done    = dn;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] idx, input int n, input logic [31:0] base,
                            output logic [31:0] ts);
    drive(1'b1, idx, 1'b0, 32'h0, 1'b0);
    ts = cyc;
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b1, base + 32'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
    idle();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      idle();
      n++;
    end
    repeat (3) idle();
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    exp_seq = '0;
    rd_start = 1'b0; rd_dv = 1'b0; rd_done = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // out_ready: 0 = held low, 1 = held high, 2 = random stalls.
  initial forever begin
    @(posedge c);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic        stall_q = 1'b0;
  logic [31:0] held_d;
  logic        held_last;

  always @(negedge c) begin : monitor
    exp_t e;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_data", out_d, held_d);
        check("stall_last", 32'(out_last), 32'(held_last));
        check("stall_valid", 32'(out_valid), 32'd1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %h expected no word", out_d);
        end else begin
          e = sb.pop_front();
          check("word", out_d, e.d);
          check("last", 32'(out_last), 32'(e.last));
        end
      end
      stall_q   = out_valid && !out_ready;
      held_d    = out_d;
      held_last = out_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ts0, ts1, ts2;

    repeat (3) step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", out_d, 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    ready_mode = 1;

    // 1: basic frame with rd_start at ts=100, header-latency check
    push_w(32'hA512_1800, 1'b0);
    push_w(32'd100, 1'b0);
    push_w(32'hAAAA_0001, 1'b0);
    push_w(32'hAAAA_0002, 1'b0);
    push_w(32'hAAAA_0003, 1'b1);
    while (cyc < 99) idle();
    drive(1'b1, 8'h12, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 3; i++) drive(1'b0, 8'h00, 1'b1, 32'hAAAA_0000 + 32'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
    idle();
    idle();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_hdr", out_d, 32'hA512_1800);
    wait_drain("drain_t1");

    // 2: 20 words into a 16-word bank, truncated
    send_frame(8'h20, 20, 32'h1000_0000, ts0);
    push_w(32'hA520_8401, 1'b0);
    push_w(ts0, 1'b0);
    for (int i = 0; i < 16; i++) push_w(32'h1000_0000 + 32'(i), i == 15);
    wait_drain("drain_t2");

    // 3: back-pressure fills both banks, third frame dropped
    do_reset();
    ready_mode = 0;
    send_frame(8'h30, 2, 32'h3000_0000, ts0);
    send_frame(8'h31, 1, 32'h3100_0000, ts1);
    send_frame(8'h32, 1, 32'h3200_0000, ts2);
    repeat (3) idle();
    check("t3_drop", 32'(drop_cnt), 32'd1);
    check("t3_held_valid", 32'(out_valid), 32'd1);
    check("t3_held_hdr", out_d, 32'hA530_1000);
    push_w(32'hA530_1000, 1'b0);
    push_w(ts0, 1'b0);
    push_w(32'h3000_0000, 1'b0);
    push_w(32'h3000_0001, 1'b1);
    push_w(32'hA531_0801, 1'b0);
    push_w(ts1, 1'b0);
    push_w(32'h3100_0000, 1'b1);
    ready_mode = 1;
    wait_drain("drain_t3");
    exp_seq = 8'd2;

    // 4: random stalls over frames of 5, 0 and 7 words
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      int n;
      n = (f == 0) ? 5 : (f == 1) ? 0 : 7;
      send_frame(8'h40 + 8'(f), n, 32'h4000_0000 + 32'(f * 256), ts0);
      push_w(hdr(8'h40 + 8'(f), 5'(n), 1'b0, exp_seq), 1'b0);
      push_w(ts0, n == 0);
      for (int i = 0; i < n; i++) push_w(32'h4000_0000 + 32'(f * 256 + i), i == n - 1);
      exp_seq++;
      wait_drain("drain_t4");
    end
    check("t4_drop", 32'(drop_cnt), 32'd1);

    // 6: dv+done same cycle, restart in W_CAP, zero-word frame
    ready_mode = 1;
    drive(1'b1, 8'h60, 1'b0, 32'h0, 1'b0);
    ts0 = cyc;
    drive(1'b0, 8'h00, 1'b1, 32'h6000_00D0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 32'h6000_00D1, 1'b1);
    idle();
    push_w(hdr(8'h60, 5'd2, 1'b0, exp_seq), 1'b0);
    push_w(ts0, 1'b0);
    push_w(32'h6000_00D0, 1'b0);
    push_w(32'h6000_00D1, 1'b1);
    exp_seq++;
    drive(1'b1, 8'h61, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 32'h6100_0000, 1'b0);
    drive(1'b1, 8'h62, 1'b0, 32'h0, 1'b0);
    ts1 = cyc;
    drive(1'b0, 8'h00, 1'b1, 32'h6200_0000, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
    idle();
    push_w(hdr(8'h62, 5'd1, 1'b0, exp_seq), 1'b0);
    push_w(ts1, 1'b0);
    push_w(32'h6200_0000, 1'b1);
    exp_seq++;
    drive(1'b1, 8'h63, 1'b0, 32'h0, 1'b0);
    ts2 = cyc;
    drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
    idle();
    push_w(hdr(8'h63, 5'd0, 1'b0, exp_seq), 1'b0);
    push_w(ts2, 1'b1);
    exp_seq++;
    wait_drain("drain_t6");
    check("t6_drop", 32'(drop_cnt), 32'd1);

    // 5: async reset with one frame held and another mid-capture
    ready_mode = 0;
    send_frame(8'h50, 2, 32'h5000_0000, ts0);
    drive(1'b1, 8'h51, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 32'h5100_0000, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 32'h5100_0001, 1'b0);
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_last", 32'(out_last), 32'd0);
    check("t5_rst_data", out_d, 32'h0);
    check("t5_rst_drop", 32'(drop_cnt), 32'd0);
    sb.delete();
    rd_start = 1'b0; rd_dv = 1'b0; rd_done = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    ready_mode = 1;
    drive(1'b0, 8'h00, 1'b1, 32'hDEAD_BEEF, 1'b1);
    repeat (4) idle();
    check("t5_quiet", 32'(out_valid), 32'd0);
    send_frame(8'h52, 1, 32'h5200_0000, ts0);
    push_w(32'hA552_0800, 1'b0);
    push_w(ts0, 1'b0);
    push_w(32'h5200_0000, 1'b1);
    wait_drain("drain_t5");
    check("end_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
